// File: rtl/gnn_node_scheduler.sv
// rtl/gnn_node_scheduler.sv - time-multiplexes one shared engine across four graph nodes
// Aggregates neighbour features in, issues one node at a time, aggregates raw outputs back.
module gnn_node_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [79:0]  in_feat,
  output logic [6:0]   eng_x0,
  output logic [6:0]   eng_x1,
  output logic [6:0]   eng_x2,
  output logic [6:0]   eng_x3,
  output logic         eng_start,
  input  logic [19:0]  eng_out0,
  input  logic [19:0]  eng_out1,
  input  logic         eng_out0_ready,
  input  logic         eng_out1_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [167:0] out_data,
  output logic         busy,
  output logic [1:0]   cur_node,
  output logic         timeout_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, AGG, DONE} state_t;
  state_t state, state_next;

  logic [79:0]       feat;
  logic signed [4:0] fv [4][4];
  logic signed [6:0] x_in [4][4];
  logic signed [19:0] raw [4][2];
  logic [167:0]      res;
  logic [CW-1:0]     cnt;
  logic              done_q, eng_done, done_edge, tmo, advance, active;

  // Fixed adjacency: nodes 0 and 3 see {1,2}; nodes 1 and 2 see {0,3}.
  function automatic logic [1:0] nb_a(input logic [1:0] n);
    nb_a = (n == 2'd0 || n == 2'd3) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] nb_b(input logic [1:0] n);
    nb_b = (n == 2'd0 || n == 2'd3) ? 2'd2 : 2'd3;
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        fv[n][k] = feat[(4*n+k)*5 +: 5];
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        x_in[n][k] = 7'(fv[n][k]) + 7'(fv[nb_a(2'(n))][k]) + 7'(fv[nb_b(2'(n))][k]);
  end

  always_comb begin
    res = '0;
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++)
        res[(2*n+k)*21 +: 21] = 21'(raw[n][k]) + 21'(raw[nb_a(2'(n))][k])
                              + 21'(raw[nb_b(2'(n))][k]);
  end

  assign eng_done  = eng_out0_ready & eng_out1_ready;
  assign done_edge = eng_done & ~done_q;
  assign tmo       = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  // A response arriving on the timeout cycle still counts as a response.
  assign advance   = (state == WAIT) && (done_edge || tmo);
  assign active    = (state == ISSUE) || (state == WAIT);

  assign eng_x0 = active ? x_in[cur_node][0] : 7'd0;
  assign eng_x1 = active ? x_in[cur_node][1] : 7'd0;
  assign eng_x2 = active ? x_in[cur_node][2] : 7'd0;
  assign eng_x3 = active ? x_in[cur_node][3] : 7'd0;

  always_comb begin
    state_next = state;
    eng_start  = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = ISSUE;
      end
      ISSUE: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (advance) state_next = (cur_node == 2'd3) ? AGG : ISSUE;
      AGG:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      feat        <= '0;
      cnt         <= '0;
      done_q      <= 1'b0;
      cur_node    <= 2'd0;
      timeout_err <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      for (int n = 0; n < 4; n++) begin
        raw[n][0] <= '0;
        raw[n][1] <= '0;
      end
    end else begin
      state  <= state_next;
      done_q <= eng_done;
      case (state)
        IDLE: if (in_valid) begin
          feat        <= in_feat;
          timeout_err <= 1'b0;
          cur_node    <= 2'd0;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (done_edge) begin
            raw[cur_node][0] <= eng_out0;
            raw[cur_node][1] <= eng_out1;
          end else if (tmo) begin
            raw[cur_node][0] <= '0;
            raw[cur_node][1] <= '0;
            timeout_err      <= 1'b1;
          end
          if (advance && cur_node != 2'd3) cur_node <= cur_node + 2'd1;
        end
        AGG: begin
          out_data  <= res;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gnn_node_scheduler.sv
// tb/tb_gnn_node_scheduler.sv - self-checking bench for gnn_node_scheduler
// Directed vector table plus random frames against an arithmetic graph model.
module tb_gnn_node_scheduler;
  logic         clk = 0, rst = 1;
  logic         in_valid = 0, in_ready;
  logic [79:0]  in_feat = '0;
  logic [6:0]   eng_x0, eng_x1, eng_x2, eng_x3;
  logic         eng_start;
  logic [19:0]  eng_out0, eng_out1;
  logic         eng_rdy;
  logic         out_valid, out_ready = 0;
  logic [167:0] out_data;
  logic         busy, timeout_err;
  logic [1:0]   cur_node;

  int tests = 0, fails = 0;

  gnn_node_scheduler #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_x3(eng_x3),
    .eng_start(eng_start), .eng_out0(eng_out0), .eng_out1(eng_out1),
    .eng_out0_ready(eng_rdy), .eng_out1_ready(eng_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cur_node(cur_node), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Engine: ready 3 cycles after start for 2 cycles; out0 = sum, out1 = x0 - x3.
  logic eng_en = 1;
  int ecnt;
  logic signed [6:0] ex [4];
  int s0, s1;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else if (eng_start) begin
      ecnt <= 1;
      ex[0] <= eng_x0; ex[1] <= eng_x1; ex[2] <= eng_x2; ex[3] <= eng_x3;
    end else if (ecnt != 0 && ecnt < 10) ecnt <= ecnt + 1;
  end
  always_comb begin
    s0 = int'(ex[0]) + int'(ex[1]) + int'(ex[2]) + int'(ex[3]);
    s1 = int'(ex[0]) - int'(ex[3]);
    eng_out0 = s0[19:0];
    eng_out1 = s1[19:0];
    eng_rdy  = eng_en && (ecnt == 3 || ecnt == 4);
  end

  int starts = 0, dbl = 0;
  logic prev_start = 0;
  logic [1:0] node_log [$];
  always @(posedge clk) begin
    if (eng_start) begin
      starts <= starts + 1;
      node_log.push_back(cur_node);
      if (prev_start) dbl <= dbl + 1;
    end
    prev_start <= eng_start;
  end

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [167:0] model(input logic [79:0] f, input bit resp);
    int fe [4][4];
    int x [4][4];
    int r [4][2];
    int nb [4][2];
    int v;
    logic [167:0] o;
    nb = '{'{1, 2}, '{0, 3}, '{0, 3}, '{1, 2}};
    o = '0;
    for (int i = 0; i < 16; i++) begin
      v = int'($signed(f[i*5 +: 5]));
      fe[i/4][i%4] = v;
    end
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        x[n][k] = fe[n][k] + fe[nb[n][0]][k] + fe[nb[n][1]][k];
    for (int n = 0; n < 4; n++) begin
      r[n][0] = resp ? x[n][0] + x[n][1] + x[n][2] + x[n][3] : 0;
      r[n][1] = resp ? x[n][0] - x[n][3] : 0;
    end
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 2; k++) begin
        v = r[n][k] + r[nb[n][0]][k] + r[nb[n][1]][k];
        o[(2*n+k)*21 +: 21] = v[20:0];
      end
    return o;
  endfunction

  function automatic logic [167:0] pk(input int a, input int b, input int c, input int d);
    logic [167:0] o;
    int v [4];
    v = '{a, b, c, d};
    o = '0;
    for (int n = 0; n < 4; n++) o[(2*n)*21 +: 21] = v[n][20:0];
    return o;
  endfunction

  function automatic logic [79:0] fill(input logic [4:0] val, input int upto);
    logic [79:0] f;
    f = '0;
    for (int i = 0; i < upto; i++) f[i*5 +: 5] = val;
    return f;
  endfunction

  task automatic run_frame(input logic [79:0] f, input logic [167:0] exp, input string nm,
                           input bit exp_terr, input int max_lat, input int hold, input bit seq);
    int g, lat;
    logic [7:0] sq;
    starts = 0;
    node_log.delete();
    @(negedge clk);
    in_feat = f;
    in_valid = 1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 0;
    chk({nm, "_busy_after_accept"}, busy, 1);
    chk({nm, "_terr_cleared"}, timeout_err, 0);
    lat = 1;
    while (!out_valid && lat < max_lat + 10) begin @(negedge clk); lat++; end
    chk({nm, "_latency_ok"}, lat <= max_lat, 1);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_terr"}, timeout_err, exp_terr);
    if (seq) begin
      sq = '0;
      foreach (node_log[i]) sq = {sq[5:0], node_log[i]};
      chk({nm, "_start_count"}, starts, 4);
      chk({nm, "_node_order"}, sq, 8'h1B);
    end
    if (hold > 0) begin
      in_valid = 1;
      g = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) g++;
      end
      chk({nm, "_hold_stable_bad_cycles"}, g, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({nm, "_in_ready_after_hs"}, in_ready, 1);
    chk({nm, "_not_accepted_at_hs"}, {busy, out_valid}, 2'b00);
    in_valid = 0;
  endtask

  typedef struct {
    logic [79:0]  feat;
    logic [167:0] exp;
    string        name;
  } vec_t;

  vec_t tbl [3];
  logic [79:0] rf;
  int g;

  initial begin
    tbl[0] = '{fill(5'd1, 16),  pk(36, 36, 36, 36),         "all_ones"};
    tbl[1] = '{fill(5'd15, 4),  pk(180, 120, 120, 120),     "node0_15"};
    tbl[2] = '{fill(5'h10, 16), pk(-576, -576, -576, -576), "all_neg16"};

    #12;
    chk("reset_outputs", {out_valid, in_ready, busy, cur_node, timeout_err, eng_start},
        {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
    chk("reset_out_data", out_data, '0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 3; i++)
      run_frame(tbl[i].feat, tbl[i].exp, tbl[i].name, 0, 27, 0, 1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 16; j++) rf[j*5 +: 5] = 5'($urandom);
      run_frame(rf, model(rf, 1), $sformatf("rand%0d", i), 0, 27, 0, 1);
    end

    eng_en = 0;
    run_frame(fill(5'd1, 16), '0, "timeout", 1, 4 * 17 + 3, 0, 1);
    eng_en = 1;
    run_frame(tbl[0].feat, tbl[0].exp, "after_timeout", 0, 27, 0, 0);

    run_frame(tbl[1].feat, tbl[1].exp, "backpressure", 0, 27, 10, 0);

    @(negedge clk);
    in_feat = tbl[2].feat;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    g = 0;
    while (!(busy && cur_node == 2'd2 && !eng_start) && g < 100) begin @(negedge clk); g++; end
    chk("reached_wait_node2", g < 100, 1);
    #2 rst = 1;
    #1;
    chk("midrst_outputs", {out_valid, in_ready, busy, cur_node, timeout_err, eng_start},
        {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
    chk("midrst_eng_x", {eng_x0, eng_x1, eng_x2, eng_x3}, '0);
    chk("midrst_out_data", out_data, '0);
    @(negedge clk);
    rst = 0;
    run_frame(tbl[0].feat, tbl[0].exp, "after_reset", 0, 27, 0, 1);

    chk("no_double_start", dbl, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/gnn_node_scheduler.md
Name: gnn_node_scheduler

Overview:
- Time-multiplexes one shared dnn_top engine across the 4 graph nodes, replacing four parallel engine instances. Weights are wired directly to the engine outside this block.
- Per frame:
  - latches 16 node features;
  - forms per-node neighbour aggregates;
  - issues them to the engine one node at a time and captures the raw outputs;
  - performs output-side neighbour aggregation;
  - presents 8 results on a valid/ready handshake.

Parameters:
- TIMEOUT, default 64: maximum cycles spent in WAIT per node before the timeout is forced.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: frame valid.
- in_ready  out  1: frame accept; equals (state==IDLE).
- in_feat  in  80: signed 5-bit features; node n, feature k at [(4n+k)*5 +: 5].
- eng_x0, eng_x1, eng_x2, eng_x3  out  7 each: signed aggregated features to the engine.
- eng_start  out  1: one-cycle start pulse to the engine in_ready.
- eng_out0, eng_out1  in  20 each: signed raw engine outputs.
- eng_out0_ready, eng_out1_ready  in  1 each: engine output-ready flags.
- out_valid  out  1: results valid.
- out_ready  in  1: results accepted.
- out_data  out  168: signed 21-bit results; node n, output k at [(2n+k)*21 +: 21].
- busy  out  1: state is not IDLE.
- cur_node  out  2: node currently issued.
- timeout_err  out  1: sticky timeout flag; cleared on the next frame accept.

Behaviour:
- Reset values: out_valid=0, out_data=0, eng_start=0, eng_x*=0, cur_node=0, busy=0, timeout_err=0, state=IDLE (so in_ready=1). Raw capture registers and feature register are cleared.
- Adjacency is fixed:
  - node0 neighbours 1,2
  - node1 neighbours 0,3
  - node2 neighbours 0,3
  - node3 neighbours 1,2
- Input aggregation: x_in[n][k] = feat[n][k] + feat[nb_a][k] + feat[nb_b][k], sign-extended to 7 bits; no overflow is possible.
- Output aggregation: res[n][k] = raw[n][k] + raw[nb_a][k] + raw[nb_b][k], computed in 21 bits with two's-complement wrap.
- eng_done = eng_out0_ready & eng_out1_ready. done_q is eng_done registered every cycle. done_edge = eng_done & ~done_q.
- FSM:
  - IDLE: when in_valid & in_ready, latch in_feat, clear timeout_err, set cur_node=0, go to ISSUE.
  - ISSUE (1 cycle): drive eng_x* = x_in[cur_node], assert eng_start=1, clear the timeout counter, go to WAIT.
  - WAIT: eng_x* held stable; eng_start=0; counter increments each cycle.
    - On done_edge: raw[cur_node] <= {eng_out0, eng_out1}.
    - Else when counter == TIMEOUT-1: raw[cur_node] <= 0 and timeout_err <= 1.
    - After either event: if cur_node==3 go to AGG, else cur_node++ and go to ISSUE.
    - A done_edge in the same cycle as the timeout wins; the data is captured and no error is flagged.
  - AGG (1 cycle): out_data <= res for all nodes, out_valid <= 1, go to DONE.
  - DONE: out_data and out_valid held stable until out_ready=1. On out_valid & out_ready, out_valid <= 0 and go to IDLE.
- Frame ordering:
  - in_ready=0 outside IDLE, so a new frame can never overlap the current one.
  - A frame is accepted no earlier than the cycle after output acceptance.
- A done_edge outside WAIT is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately; a partially processed frame is discarded; eng_start is forced low.
- eng_start is never asserted for two consecutive cycles.

Test Plan:
Bench engine model: fixed latency L=3 from eng_start to eng_done=1, held for 2 cycles; out0 = x0+x1+x2+x3; out1 = x0-x3.
- All 16 features = +1 -> each x_in = 3, raw out0 = 12 -> every out0 result = 36, every out1 result = 0. out_valid within 4*(L+3)+3 cycles of accept; eng_start pulses exactly 4 times, with cur_node 0,1,2,3 in order.
- Node0 features all +15, others 0 -> raw out0 = 60,60,60,0 -> results out0: node0=180, node1=120, node2=120, node3=120; all out1 = 0.
- All features -16 -> x_in = -48 per feature, raw out0 = -192 -> every out0 result = -576 (correct sign in 21 bits).
- Engine never responds, TIMEOUT=16 -> each node leaves WAIT after 16 cycles; timeout_err=1; out_data all zero; out_valid asserted. The next frame accept clears timeout_err.
- out_ready held 0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a pending in_valid is not accepted. After the handshake, in_ready=1 the next cycle.
- rst pulsed while in WAIT for node 2 -> all outputs return to reset values asynchronously. A following all-ones frame still yields out0 = 36 for every node.
